// File: rtl/challenge_expand.sv
// challenge_expand
// Expands the 256-bit challenge hash h_t into the opened-round list lc and
// the unopened-party list lp. The sampler is bit-serial and reads chunks from
// the MSB end of the hash:
//   - CHAL consumes CB-bit chunks and keeps the first TAU distinct values.
//   - PART consumes TAU PB-bit chunks with no duplicate check.
// If the hash runs out before both lists are full, the run ends with
// expand_err set. lc and lp keep whatever was filled; unfilled entries read 0.
//
// Optional build macro CHALLENGE_SORT_EN:
//   Adds a SORT state between CHAL and PART. SORT runs TAU odd/even
//   compare-swap passes so that lc leaves in ascending order. When the macro
//   is undefined, lc is in acceptance order.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high; dominates everything
//   expand_start level request; sampled only in IDLE
//   h_t_i        challenge hash; held stable while expand_start is high
//   lc           {LC[0],..,LC[TAU-1]}, LC[0] in MSBs, 5 bits per entry
//   lp           {LP[0],..,LP[TAU-1]}, same packing
//   expand_end   result valid; held until expand_start drops
//   expand_err   hash exhausted before the lists were filled
//
// state | meaning
// IDLE  | waiting for expand_start with no result pending
// CHAL  | sampling distinct round indices into lc
// SORT  | odd/even transposition passes on lc (CHALLENGE_SORT_EN only)
// PART  | sampling party indices into lp
// DONE  | result (or error) held until expand_start drops
module challenge_expand #(
   parameter int M      = 8,
   parameter int TAU    = 4,
   parameter int NPARTY = 16,
   parameter int HASH_W = 256
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                expand_start,
   input  logic [HASH_W-1:0]   h_t_i,
   output logic [TAU*5-1:0]    lc,
   output logic [TAU*5-1:0]    lp,
   output logic                expand_end,
   output logic                expand_err
);

   localparam int CB    = $clog2(M);
   localparam int PB    = $clog2(NPARTY);
   localparam int PTR_W = $clog2(HASH_W + 1);
   localparam int CNT_W = $clog2(TAU + 1);
   localparam int HB    = $clog2(HASH_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHAL,
`ifdef CHALLENGE_SORT_EN
      S_SORT,
`endif
      S_PART,
      S_DONE
   } state_t;

   state_t                   state_q, state_d;
   logic [PTR_W-1:0]         ptr_q, ptr_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [TAU-1:0][CB-1:0]   lc_q, lc_d;
   logic [TAU-1:0][PB-1:0]   lp_q, lp_d;
   logic                     end_q, end_d;
   logic                     err_q, err_d;

   logic [HB-1:0]            base;
   logic [CB-1:0]            chal_chunk;
   logic [PB-1:0]            part_chunk;
   logic                     dup;

   // The base is only meaningful while the next chunk still fits inside the
   // hash; the exhaustion check keeps the out-of-range case from being used.
   assign base       = HB'(HASH_W - 1) - HB'(ptr_q);
   assign chal_chunk = h_t_i[base -: CB];
   assign part_chunk = h_t_i[base -: PB];

   always_comb begin
      dup = 1'b0;
      for (int i = 0; i < TAU; i++) begin
         if ((CNT_W'(i) < cnt_q) && (lc_q[i] == chal_chunk)) dup = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      lc_d    = lc_q;
      lp_d    = lp_q;
      end_d   = end_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (expand_start && !end_q && !err_q) begin
               ptr_d   = '0;
               cnt_d   = '0;
               lc_d    = '0;
               lp_d    = '0;
               state_d = S_CHAL;
            end
         end
         S_CHAL: begin
            if (int'(ptr_q) + CB > HASH_W) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               ptr_d = ptr_q + PTR_W'(CB);
               if (!dup) begin
                  for (int i = 0; i < TAU; i++) begin
                     if (CNT_W'(i) == cnt_q) lc_d[i] = chal_chunk;
                  end
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == CNT_W'(TAU - 1)) begin
                     cnt_d = '0;
`ifdef CHALLENGE_SORT_EN
                     state_d = S_SORT;
`else
                     state_d = S_PART;
`endif
                  end
               end
            end
         end
`ifdef CHALLENGE_SORT_EN
         S_SORT: begin
            // cnt_q doubles as the pass index; its LSB picks even or odd pairs.
            for (int i = 0; i < TAU - 1; i++) begin
               if (((i % 2) == int'(cnt_q[0])) && (lc_q[i] > lc_q[i+1])) begin
                  lc_d[i]   = lc_q[i+1];
                  lc_d[i+1] = lc_q[i];
               end
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(TAU - 1)) begin
               cnt_d   = '0;
               state_d = S_PART;
            end
         end
`endif
         S_PART: begin
            if (int'(ptr_q) + PB > HASH_W) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               ptr_d = ptr_q + PTR_W'(PB);
               for (int i = 0; i < TAU; i++) begin
                  if (CNT_W'(i) == cnt_q) lp_d[i] = part_chunk;
               end
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(TAU - 1)) state_d = S_DONE;
            end
         end
         S_DONE: begin
            // A clean finish always raises end for at least one cycle, even
            // if start already dropped mid-run.
            if (!end_q && !err_q) begin
               end_d = 1'b1;
            end else if (!expand_start) begin
               end_d   = 1'b0;
               err_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         lc_q    <= '0;
         lp_q    <= '0;
         end_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         lc_q    <= lc_d;
         lp_q    <= lp_d;
         end_q   <= end_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      lc = '0;
      lp = '0;
      for (int i = 0; i < TAU; i++) begin
         lc[(TAU-1-i)*5 +: 5] = 5'(lc_q[i]);
         lp[(TAU-1-i)*5 +: 5] = 5'(lp_q[i]);
      end
   end

   assign expand_end = end_q;
   assign expand_err = err_q;

endmodule

// File: tb/tb_challenge_expand.sv
// Scoreboard bench for challenge_expand: stimulus queues the expected lists,
// error flag and finishing edge. A monitor pops an entry whenever the DUT
// raises expand_end or expand_err.
module tb_challenge_expand;

   logic          clk = 1'b0;
   logic          reset;
   logic          expand_start;
   logic [255:0]  h_t_i;
   logic [19:0]   lc, lp;
   logic          expand_end, expand_err;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;

   typedef struct {
      logic [19:0] lc;
      logic [19:0] lp;
      logic        err;
      int          edge_n;
   } exp_t;
   exp_t sb_q[$];

   challenge_expand dut (
      .clk          (clk),
      .reset        (reset),
      .expand_start (expand_start),
      .h_t_i        (h_t_i),
      .lc           (lc),
      .lp           (lp),
      .expand_end   (expand_end),
      .expand_err   (expand_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

`ifdef CHALLENGE_SORT_EN
   localparam int SORT_LAT = 4;
`else
   localparam int SORT_LAT = 0;
`endif

   function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
      return {5'(a), 5'(b), 5'(c), 5'(d)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: one pop per rising result/error indication.
   bit   seen = 1'b0;
   exp_t m_e;
   always @(negedge clk) begin
      if ((expand_end || expand_err) && !seen) begin
         seen = 1'b1;
         if (sb_q.size() == 0) begin
            chk("unexpected_output", {30'd0, expand_end, expand_err}, 32'd0);
         end else begin
            m_e = sb_q.pop_front();
            chk("mon_lc", 32'(lc), 32'(m_e.lc));
            chk("mon_lp", 32'(lp), 32'(m_e.lp));
            chk("mon_err", 32'(expand_err), 32'(m_e.err));
            chk("mon_end", 32'(expand_end), 32'(!m_e.err));
            chk("mon_edge", 32'(cyc), 32'(m_e.edge_n));
         end
      end else if (!expand_end && !expand_err) begin
         seen = 1'b0;
      end
   end

   // Called at a negedge. lat counts edges with the start-sampling edge as 1.
   task automatic run(input string name, input logic [255:0] h,
                      input logic [19:0] elc, input logic [19:0] elp,
                      input logic eerr, input int lat, input int hold,
                      input bit drop_early);
      exp_t e;
      int   n;
      h_t_i        = h;
      expand_start = 1'b1;
      e.lc = elc; e.lp = elp; e.err = eerr; e.edge_n = cyc + lat;
      sb_q.push_back(e);
      n = 0;
      while (!(expand_end || expand_err) && n < 300) begin
         @(negedge clk);
         n++;
         if (drop_early && n == 2) expand_start = 1'b0;
      end
      if (n >= 300) chk({name, "_timeout"}, 32'(n), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({name, "_hold_end"}, 32'(expand_end), 32'(!eerr));
         chk({name, "_hold_err"}, 32'(expand_err), 32'(eerr));
         chk({name, "_hold_lc"}, 32'(lc), 32'(elc));
         chk({name, "_hold_lp"}, 32'(lp), 32'(elp));
      end
      expand_start = 1'b0;
      @(negedge clk);
      chk({name, "_clr_end"}, 32'(expand_end), 32'd0);
      chk({name, "_clr_err"}, 32'(expand_err), 32'd0);
      chk({name, "_keep_lc"}, 32'(lc), 32'(elc));
   endtask

   logic [255:0] h_basic, h_dup, h_sort;
   logic [19:0]  lc_dup_exp, lc_sort_exp;

   initial begin
      h_basic = {28'h053F0A5, 228'd0};
      h_dup   = {18'b111_111_011_011_101_000, 16'h1234, 222'd0};
      h_sort  = {12'b110_010_111_001, 16'hF0A5, 228'd0};
`ifdef CHALLENGE_SORT_EN
      lc_dup_exp  = pk(0, 3, 5, 7);
      lc_sort_exp = pk(1, 2, 6, 7);
`else
      lc_dup_exp  = pk(7, 3, 5, 0);
      lc_sort_exp = pk(6, 2, 7, 1);
`endif
      reset        = 1'b1;
      expand_start = 1'b0;
      h_t_i        = '0;
      repeat (3) @(negedge clk);
      chk("rst_lc", 32'(lc), 32'd0);
      chk("rst_lp", 32'(lp), 32'd0);
      chk("rst_end", 32'(expand_end), 32'd0);
      chk("rst_err", 32'(expand_err), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      run("basic", h_basic, pk(0, 1, 2, 3), pk(15, 0, 10, 5), 1'b0, 10 + SORT_LAT, 5, 1'b0);
      run("rerun", h_basic, pk(0, 1, 2, 3), pk(15, 0, 10, 5), 1'b0, 10 + SORT_LAT, 0, 1'b0);
      run("dup", h_dup, lc_dup_exp, pk(1, 2, 3, 4), 1'b0, 12 + SORT_LAT, 0, 1'b1);
      run("exhaust", '0, pk(0, 0, 0, 0), pk(0, 0, 0, 0), 1'b1, 87, 3, 1'b0);
      run("sort", h_sort, lc_sort_exp, pk(15, 0, 10, 5), 1'b0, 10 + SORT_LAT, 1, 1'b0);

      // Reset during a run: sampled at edge 4, must abort with no output.
      h_t_i        = h_basic;
      expand_start = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_lc", 32'(lc), 32'd0);
      chk("abort_lp", 32'(lp), 32'd0);
      chk("abort_end", 32'(expand_end), 32'd0);
      chk("abort_err", 32'(expand_err), 32'd0);
      reset        = 1'b0;
      expand_start = 1'b0;
      @(negedge clk);
      chk("abort_idle_lc", 32'(lc), 32'd0);
      run("post_rst", h_basic, pk(0, 1, 2, 3), pk(15, 0, 10, 5), 1'b0, 10 + SORT_LAT, 0, 1'b0);

      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
